// File: rtl/sccb_write_arbiter.sv
// Two-requester SCCB register-write arbiter driving a small I2C core register bus.
// Latency: done pulses 7 cycles after grant plus cycles spent waiting on bus_ready.
// Backpressure: requests wait in IDLE while busy; bus_ready stalls the wait states.
module sccb_write_arbiter #(
    parameter int          MAX_RETRY   = 3,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] req0_slave,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_data,
    output logic       done0,
    output logic       err0,
    input  logic       req1,
    input  logic [7:0] req1_slave,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_data,
    output logic       done1,
    output logic       err1,
    output logic [2:0] bus_address,
    output logic [7:0] bus_writedata,
    output logic       bus_write,
    input  logic       bus_ready,
    input  logic       bus_success,
    output logic       busy
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        IDLE, W_SLV, W_REG, W_DAT, W_CTL, WAIT_BUSY, WAIT_DONE, RESP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      slave_q, slave_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      data_q, data_d;
    logic            gnt_q, gnt_d;     // owner of the transaction in flight
    logic            last_q, last_d;   // requester granted most recently
    logic            err_q, err_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            pick;
    logic            tmo_hit;

    // On contention the requester not served last wins; otherwise whoever asks.
    assign pick    = (req0 && req1) ? ~last_q : req1;
    assign tmo_hit = (tmo_q == (TIMEOUT_CYC - 16'd1));
    assign busy    = (state_q != IDLE);

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            slave_q <= 8'h00;
            reg_q   <= 8'h00;
            data_q  <= 8'h00;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            retry_q <= '0;
            tmo_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            slave_q <= slave_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, counter and bus/response output decode.
    always_comb begin
        state_d       = state_q;
        slave_d       = slave_q;
        reg_d         = reg_q;
        data_d        = data_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        err_d         = err_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        bus_write     = 1'b0;
        bus_address   = 3'b000;
        bus_writedata = 8'h00;
        done0         = 1'b0;
        err0          = 1'b0;
        done1         = 1'b0;
        err1          = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    slave_d = pick ? req1_slave : req0_slave;
                    reg_d   = pick ? req1_reg   : req0_reg;
                    data_d  = pick ? req1_data  : req0_data;
                    retry_d = '0;
                    err_d   = 1'b0;
                    state_d = W_SLV;
                end
            end
            W_SLV: begin
                bus_write     = 1'b1;
                bus_address   = 3'b001;
                bus_writedata = slave_q;
                state_d       = W_REG;
            end
            W_REG: begin
                bus_write     = 1'b1;
                bus_address   = 3'b010;
                bus_writedata = reg_q;
                state_d       = W_DAT;
            end
            W_DAT: begin
                bus_write     = 1'b1;
                bus_address   = 3'b011;
                bus_writedata = data_q;
                state_d       = W_CTL;
            end
            W_CTL: begin
                bus_write     = 1'b1;
                bus_address   = 3'b000;
                bus_writedata = 8'h01;
                tmo_d         = 16'd0;
                state_d       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!bus_ready) begin
                    tmo_d   = 16'd0;
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (bus_ready) begin
                    if (bus_success) begin
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = W_SLV;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RESP: begin
                done0   = ~gnt_q;
                err0    = ~gnt_q & err_q;
                done1   = gnt_q;
                err1    = gnt_q & err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
`timescale 1ns/1ps
module tb_sccb_write_arbiter;

    localparam int          MAXR = 3;
    localparam logic [15:0] TMO  = 16'd100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] req0_slave = 8'h00, req0_reg = 8'h00, req0_data = 8'h00;
    logic [7:0] req1_slave = 8'h00, req1_reg = 8'h00, req1_data = 8'h00;
    logic       bus_ready = 1'b1, bus_success = 1'b0;
    logic       done0, err0, done1, err1, bus_write, busy;
    logic [2:0] bus_address;
    logic [7:0] bus_writedata;

    sccb_write_arbiter #(.MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req0_slave(req0_slave), .req0_reg(req0_reg), .req0_data(req0_data),
        .done0(done0), .err0(err0),
        .req1(req1), .req1_slave(req1_slave), .req1_reg(req1_reg), .req1_data(req1_data),
        .done1(done1), .err1(err1),
        .bus_address(bus_address), .bus_writedata(bus_writedata), .bus_write(bus_write),
        .bus_ready(bus_ready), .bus_success(bus_success), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic id; logic err; int cyc; } done_t;
    typedef struct {
        logic who; logic [7:0] s; logic [7:0] r; logic [7:0] d;
        int fails; int low; bit nofall;
        logic exp_err; int exp_att; int exp_lat;
    } vec_t;

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    bus_dirty = 0, both_done = 0;
    logic  busy_prev = 1'b0;
    wr_t   wq[$];
    done_t dq[$];
    int    busy_rise[$];

    // bus model knobs: failures to report, ready-low length, never-fall mode
    int bm_fails = 0, bm_low = 2, bm_cnt = 0;
    bit bm_nofall = 0;

    // Monitor: samples DUT outputs on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus_write) wq.push_back('{bus_address, bus_writedata});
        else if (bus_address != 3'd0 || bus_writedata != 8'd0) bus_dirty++;
        if (done0) dq.push_back('{1'b0, err0, cyc});
        if (done1) dq.push_back('{1'b1, err1, cyc});
        if (done0 && done1) both_done++;
        if (busy && !busy_prev) busy_rise.push_back(cyc);
        busy_prev = busy;
    end

    // I2C core model: goes busy after the start command, then reports a result.
    initial forever begin
        @(negedge clk);
        if (bm_cnt > 0) begin
            bm_cnt--;
            if (bm_cnt == 0) begin
                bus_ready = 1'b1;
                if (bm_fails > 0) begin bus_success = 1'b0; bm_fails--; end
                else bus_success = 1'b1;
            end
        end else if (bus_write && bus_address == 3'd0 && bus_writedata == 8'h01 && !bm_nofall) begin
            bus_ready = 1'b0;
            bm_cnt    = bm_low;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bm_set(input int fails, input int low, input bit nofall);
        bm_fails = fails; bm_low = low; bm_nofall = nofall;
    endtask

    task automatic drive_req(input logic who, input logic on,
                             input logic [7:0] s, input logic [7:0] r, input logic [7:0] d);
        if (who) begin req1 = on; req1_slave = s; req1_reg = r; req1_data = d; end
        else     begin req0 = on; req0_slave = s; req0_reg = r; req0_data = d; end
    endtask

    // Returns at the edge where done is sampled, plus 1ns, so the caller acts as a requester.
    task automatic wait_done(input string name, output done_t ev, output bit ok);
        int t = 0;
        ok = 0;
        ev = '{1'b0, 1'b0, 0};
        while (dq.size() == 0 && t < 3000) begin @(posedge clk); t++; end
        if (dq.size() != 0) begin
            ev = dq.pop_front();
            ok = 1;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, t);
        end
        #1;
    endtask

    // Reference: attempts and error derived from the retry/timeout rules.
    function automatic void model_txn(input int fails, input bit nofall,
                                      output int att, output logic err);
        if (nofall)             begin att = 1;        err = 1'b1; end
        else if (fails > MAXR)  begin att = MAXR + 1; err = 1'b1; end
        else                    begin att = fails + 1; err = 1'b0; end
    endfunction

    task automatic check_writes(input string name, input logic [7:0] s, input logic [7:0] r,
                                input logic [7:0] d, input int att);
        int bad = 0;
        logic [2:0] ea;
        logic [7:0] ed;
        check({name, "_nwrites"}, wq.size(), 4 * att);
        for (int i = 0; i < wq.size(); i++) begin
            case (i % 4)
                0:       begin ea = 3'd1; ed = s; end
                1:       begin ea = 3'd2; ed = r; end
                2:       begin ea = 3'd3; ed = d; end
                default: begin ea = 3'd0; ed = 8'h01; end
            endcase
            if (wq[i].a !== ea || wq[i].d !== ed) bad++;
        end
        check({name, "_wrdata"}, bad, 0);
        wq.delete();
    endtask

    task automatic run_one(input int idx, input vec_t v);
        done_t ev;
        bit    ok;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wq.delete(); busy_rise.delete();
        bm_set(v.fails, v.low, v.nofall);
        @(posedge clk); #1;
        drive_req(v.who, 1'b1, v.s, v.r, v.d);
        wait_done(nm, ev, ok);
        drive_req(v.who, 1'b0, 8'h00, 8'h00, 8'h00);
        if (ok) begin
            check({nm, "_id"}, ev.id, v.who);
            check({nm, "_err"}, ev.err, v.exp_err);
            check_writes(nm, v.s, v.r, v.d, v.exp_att);
            check({nm, "_starts"}, busy_rise.size(), 1);
            if (busy_rise.size() > 0) check({nm, "_latency"}, ev.cyc - busy_rise[0], v.exp_lat);
        end
        repeat (3) @(posedge clk);
        check({nm, "_single_done"}, dq.size(), 0);
        dq.delete();
    endtask

    vec_t tbl[6];

    initial begin
        done_t      ev;
        bit         ok;
        int         att, f, lw, prev_done, t;
        logic       e, first, model_last;
        logic [7:0] rs, rr, rd;
        logic [7:0] fs[2], fr[2], fd[2];
        int         mask;

        //            who  slave  reg    data   fail low nofall err att lat
        tbl[0] = '{1'b0, 8'h60, 8'h12, 8'h80, 0, 20, 1'b0, 1'b0, 1, 24};
        tbl[1] = '{1'b1, 8'h42, 8'hA5, 8'h3C, 0, 2,  1'b0, 1'b0, 1, 6};
        tbl[2] = '{1'b0, 8'h21, 8'h07, 8'hFF, 3, 2,  1'b0, 1'b0, 4, 24};
        tbl[3] = '{1'b0, 8'h5A, 8'h5B, 8'h5C, 4, 3,  1'b0, 1'b1, 4, 28};
        tbl[4] = '{1'b1, 8'h11, 8'h22, 8'h33, 0, 2,  1'b1, 1'b1, 1, 104};
        tbl[5] = '{1'b1, 8'h60, 8'h13, 8'h81, 1, 5,  1'b0, 1'b0, 2, 18};

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, bus_write, bus_address, bus_writedata, done0, err0, done1, err1}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // contention from reset: req0, then req1, then req0 again (req0 re-requests)
        wq.delete(); dq.delete();
        bm_set(0, 2, 0);
        drive_req(1'b0, 1'b1, 8'h30, 8'h31, 8'h32);
        drive_req(1'b1, 1'b1, 8'h40, 8'h41, 8'h42);
        wait_done("cont_a", ev, ok);
        drive_req(1'b0, 1'b1, 8'h50, 8'h51, 8'h52);
        check("cont_a_id", ev.id, 0);
        check_writes("cont_a", 8'h30, 8'h31, 8'h32, 1);
        wait_done("cont_b", ev, ok);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("cont_b_id", ev.id, 1);
        check_writes("cont_b", 8'h40, 8'h41, 8'h42, 1);
        wait_done("cont_c", ev, ok);
        drive_req(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("cont_c_id", ev.id, 0);
        check_writes("cont_c", 8'h50, 8'h51, 8'h52, 1);
        repeat (3) @(posedge clk);

        // directed vectors
        for (int i = 0; i < 6; i++) run_one(i, tbl[i]);

        // asynchronous reset in the middle of WAIT_DONE with req1 pending
        bm_set(0, 40, 0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 8'h77, 8'h78, 8'h79);
        t = 0;
        do begin @(negedge clk); t++; end while (!busy && t < 50);
        drive_req(1'b1, 1'b1, 8'h6A, 8'h6B, 8'h6C);
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_async_outputs", {busy, bus_write, done0, done1}, 0);
        bm_cnt = 0; bus_ready = 1'b1; bm_fails = 0;
        repeat (2) @(negedge clk);
        check("rst_hold_outputs", {busy, bus_write, bus_address, bus_writedata, done0, err0, done1, err1}, 0);
        drive_req(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        check("rst_no_done", dq.size(), 0);
        wq.delete(); dq.delete();
        bm_set(0, 2, 0);
        wait_done("rst_req1", ev, ok);
        drive_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        check("rst_req1_id", ev.id, 1);
        check("rst_req1_err", ev.err, 0);
        check_writes("rst_req1", 8'h6A, 8'h6B, 8'h6C, 1);
        repeat (3) @(posedge clk);

        // back-to-back random writes on req1 held high
        wq.delete(); dq.delete(); busy_rise.delete();
        f  = $urandom_range(0, 4);
        lw = $urandom_range(2, 12);
        rs = 8'($urandom); rr = 8'($urandom); rd = 8'($urandom);
        bm_set(f, lw, 0);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, rs, rr, rd);
        prev_done = -1;
        for (int k = 0; k < 10; k++) begin
            wait_done($sformatf("b2b%0d", k), ev, ok);
            if (!ok) break;
            model_txn(f, 1'b0, att, e);
            check($sformatf("b2b%0d_id", k), ev.id, 1);
            check($sformatf("b2b%0d_err", k), ev.err, e);
            check_writes($sformatf("b2b%0d", k), rs, rr, rd, att);
            if (busy_rise.size() > 0) begin
                if (prev_done >= 0)
                    check($sformatf("b2b%0d_restart", k), busy_rise[0], prev_done + 2);
                check($sformatf("b2b%0d_latency", k), ev.cyc - busy_rise[0], att * (lw + 4));
                void'(busy_rise.pop_front());
            end
            prev_done = ev.cyc;
            if (k < 9) begin
                f  = $urandom_range(0, 4);
                lw = $urandom_range(2, 12);
                rs = 8'($urandom); rr = 8'($urandom); rd = 8'($urandom);
                bm_set(f, lw, 0);
                drive_req(1'b1, 1'b1, rs, rr, rd);
            end else begin
                drive_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            end
        end
        repeat (3) @(posedge clk);

        // random simultaneous requests against a round-robin model
        model_last = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mask = $urandom_range(1, 3);
            for (int j = 0; j < 2; j++) begin
                fs[j] = 8'($urandom); fr[j] = 8'($urandom); fd[j] = 8'($urandom);
            end
            wq.delete(); dq.delete();
            bm_set(0, $urandom_range(2, 6), 0);
            @(posedge clk); #1;
            if (mask[0]) drive_req(1'b0, 1'b1, fs[0], fr[0], fd[0]);
            if (mask[1]) drive_req(1'b1, 1'b1, fs[1], fr[1], fd[1]);
            first = (mask == 3) ? ~model_last : (mask == 2);
            for (int n = 0; n < ((mask == 3) ? 2 : 1); n++) begin
                logic want;
                want = (n == 0) ? first : ~first;
                wait_done($sformatf("rr%0d_%0d", k, n), ev, ok);
                if (!ok) break;
                drive_req(ev.id, 1'b0, 8'h00, 8'h00, 8'h00);
                check($sformatf("rr%0d_%0d_id", k, n), ev.id, want);
                check($sformatf("rr%0d_%0d_err", k, n), ev.err, 0);
                check_writes($sformatf("rr%0d_%0d", k, n), fs[want], fr[want], fd[want], 1);
                model_last = want;
            end
            drive_req(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            drive_req(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            repeat (2) @(posedge clk);
        end

        check("idle_bus_zero", bus_dirty, 0);
        check("exclusive_done", both_done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
